// File: rtl/reg_file_pkg.sv
// Shared datapath definitions: register file geometry, flag reset values
// and the ALU op encodings used around the register file.
package reg_file_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 3;

  localparam logic SC_RESET   = 1'b0;
  localparam logic ZERO_RESET = 1'b0;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_LSH  = 3'd2,
    ALU_RSH  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_OR   = 3'd5,
    ALU_XOR  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

endpackage

// File: rtl/reg_file_if.sv
// Register file access bus: two read ports, one write port and the
// shift-carry / zero flag controls.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int unsigned DataWidth = DATA_WIDTH,
  parameter int unsigned AddrWidth = ADDR_WIDTH
);

  logic [AddrWidth-1:0] RaddrA;
  logic [AddrWidth-1:0] RaddrB;
  logic                 WriteEn;
  logic [AddrWidth-1:0] Waddr;
  logic [DataWidth-1:0] DataIn;
  logic                 ScWrEn;
  logic                 ScNext;
  logic                 ZeroWrEn;
  logic                 ZeroIn;
  logic [DataWidth-1:0] DataOutA;
  logic [DataWidth-1:0] DataOutB;
  logic                 ScOut;
  logic                 ZeroFlag;

  modport master (
    output RaddrA, RaddrB, WriteEn, Waddr, DataIn,
    output ScWrEn, ScNext, ZeroWrEn, ZeroIn,
    input  DataOutA, DataOutB, ScOut, ZeroFlag
  );

  modport slave (
    input  RaddrA, RaddrB, WriteEn, Waddr, DataIn,
    input  ScWrEn, ScNext, ZeroWrEn, ZeroIn,
    output DataOutA, DataOutB, ScOut, ZeroFlag
  );

endinterface

// File: rtl/reg_file_flag_reg.sv
// Single-bit enable flop with synchronous reset, used for the SC and zero flags.
module reg_file_flag_reg #(
  parameter logic ResetVal = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q <= ResetVal;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports with write-first
// bypass, one synchronous write port, plus shift-carry and zero flag registers.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DataWidth = DATA_WIDTH,
  parameter int unsigned AddrWidth = ADDR_WIDTH
) (
  input logic     Clk,
  input logic     Reset,
  reg_file_if.slave rf
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [DataWidth-1:0] regs [Depth];
  logic                 hit_a;
  logic                 hit_b;

  // Storage array; reset wins over a write on the same edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      regs <= '{default: '0};
    end else if (rf.WriteEn) begin
      regs[rf.Waddr] <= rf.DataIn;
    end
  end

  // Write-first bypass kept to a single 2:1 mux behind the array read
  assign hit_a       = rf.WriteEn && (rf.Waddr == rf.RaddrA);
  assign hit_b       = rf.WriteEn && (rf.Waddr == rf.RaddrB);
  assign rf.DataOutA = hit_a ? rf.DataIn : regs[rf.RaddrA];
  assign rf.DataOutB = hit_b ? rf.DataIn : regs[rf.RaddrB];

  reg_file_flag_reg #(.ResetVal(SC_RESET)) u_sc_reg (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (rf.ScWrEn),
    .d     (rf.ScNext),
    .q     (rf.ScOut)
  );

  reg_file_flag_reg #(.ResetVal(ZERO_RESET)) u_zero_reg (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (rf.ZeroWrEn),
    .d     (rf.ZeroIn),
    .q     (rf.ZeroFlag)
  );

endmodule
